// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit:
// FSM state encoding, datapath width and the default reset PC.
package instr_fetch_unit_pkg;

   localparam int WORD_W = 16;
   localparam int CNT_W  = 8;

   localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      FAULT = 2'b10
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter register: parallel load for branches, +1 after a
// completed fetch (wraps modulo 2^16), asynchronous active-low reset.
import instr_fetch_unit_pkg::*;

module pc_register #(
   parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [WORD_W-1:0] load_value,
   input  logic              incr,
   output logic [WORD_W-1:0] pc
);

   logic [WORD_W-1:0] pc_r;

   // PC state; load wins should both ever be raised, though the FSM never does
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_r <= RESET_PC;
      end else if (load) begin
         pc_r <= load_value;
      end else if (incr) begin
         pc_r <= pc_r + 16'h0001;
      end else begin
         pc_r <= pc_r;
      end
   end

   assign pc = pc_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/WAIT/FAULT handshake with memory, instruction
// register and wait-timeout supervision. Outputs come only from registers.
import instr_fetch_unit_pkg::*;

module instr_fetch_unit #(
   parameter logic [WORD_W-1:0] RESET_PC       = DEFAULT_RESET_PC,
   parameter int unsigned       TIMEOUT_CYCLES = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              fetch,
   input  logic              pc_load,
   input  logic [WORD_W-1:0] pc_load_value,
   input  logic              fault_clr,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              mem_rd,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] IR,
   output logic [WORD_W-1:0] PC,
   output logic              ir_valid,
   output logic              busy,
   output logic              fetch_fault
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

   fetch_state_e      state_r;
   fetch_state_e      next_state_s;
   logic [CNT_W-1:0]  wait_cnt_r;
   logic [CNT_W-1:0]  wait_cnt_next_s;
   logic [CNT_W-1:0]  wait_cnt_inc_s;
   logic [WORD_W-1:0] ir_r;
   logic              ir_valid_r;
   logic              ir_load_s;
   logic              pc_load_en_s;
   logic              pc_incr_s;
   logic [WORD_W-1:0] pc_s;

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clock      (clock),
      .reset      (reset),
      .load       (pc_load_en_s),
      .load_value (pc_load_value),
      .incr       (pc_incr_s),
      .pc         (pc_s)
   );

   // Next-state, wait-counter and datapath-enable decode
   always_comb begin
      next_state_s    = state_r;
      wait_cnt_next_s = wait_cnt_r;
      wait_cnt_inc_s  = wait_cnt_r + 8'd1;
      ir_load_s       = 1'b0;
      pc_load_en_s    = 1'b0;
      pc_incr_s       = 1'b0;
      case (state_r)
         IDLE: begin
            // a same-edge branch lands before WAIT, so the fetch sees the new PC
            pc_load_en_s = pc_load;
            if (fetch) begin
               next_state_s    = WAIT;
               wait_cnt_next_s = 8'd0;
            end else begin
               next_state_s = IDLE;
            end
         end
         WAIT: begin
            if (mem_ready) begin
               ir_load_s    = 1'b1;
               pc_incr_s    = 1'b1;
               next_state_s = IDLE;
            end else begin
               wait_cnt_next_s = wait_cnt_inc_s;
               if (wait_cnt_inc_s == TIMEOUT_C) begin
                  next_state_s = FAULT;
               end else begin
                  next_state_s = WAIT;
               end
            end
         end
         FAULT: begin
            if (fault_clr) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = FAULT;
            end
         end
         default: begin
            next_state_s    = IDLE;
            wait_cnt_next_s = 8'd0;
         end
      endcase
   end

   // State and wait-counter registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         wait_cnt_r <= 8'd0;
      end else begin
         state_r    <= next_state_s;
         wait_cnt_r <= wait_cnt_next_s;
      end
   end

   // Instruction register and its one-cycle valid pulse
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ir_r       <= 16'h0000;
         ir_valid_r <= 1'b0;
      end else begin
         ir_r       <= ir_load_s ? mem_rdata : ir_r;
         ir_valid_r <= ir_load_s;
      end
   end

   assign mem_rd      = (state_r == WAIT);
   assign busy        = (state_r == WAIT);
   assign fetch_fault = (state_r == FAULT);
   assign mem_addr    = pc_s;
   assign PC          = pc_s;
   assign IR          = ir_r;
   assign ir_valid    = ir_valid_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed fetch scenarios with a
// transaction-level reference model and per-cycle output comparison.
module tb_instr_fetch_unit;

   localparam int TIMEOUT = 15;

   logic        clock;
   logic        reset;
   logic        fetch;
   logic        pc_load;
   logic [15:0] pc_load_value;
   logic        fault_clr;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [15:0] IR;
   logic [15:0] PC;
   logic        ir_valid;
   logic        busy;
   logic        fetch_fault;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   // reference model: 0 = idle, 1 = waiting on memory, 2 = faulted
   int          m_phase;
   int          m_waited;
   logic [15:0] m_pc;
   logic [15:0] m_ir;
   logic        m_irv;

   instr_fetch_unit dut (
      .clock         (clock),
      .reset         (reset),
      .fetch         (fetch),
      .pc_load       (pc_load),
      .pc_load_value (pc_load_value),
      .fault_clr     (fault_clr),
      .mem_rdata     (mem_rdata),
      .mem_ready     (mem_ready),
      .mem_rd        (mem_rd),
      .mem_addr      (mem_addr),
      .IR            (IR),
      .PC            (PC),
      .ir_valid      (ir_valid),
      .busy          (busy),
      .fetch_fault   (fetch_fault)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase  = 0;
      m_waited = 0;
      m_pc     = 16'h0000;
      m_ir     = 16'h0000;
      m_irv    = 1'b0;
   endtask

   // advance the model by one rising edge using the inputs about to be sampled
   task automatic model_step();
      m_irv = 1'b0;
      if (m_phase == 0) begin
         if (pc_load) m_pc = pc_load_value;
         if (fetch) begin
            m_phase  = 1;
            m_waited = 0;
         end
      end else if (m_phase == 1) begin
         if (mem_ready) begin
            m_ir    = mem_rdata;
            m_pc    = 16'((32'(m_pc) + 1) % 65536);
            m_irv   = 1'b1;
            m_phase = 0;
         end else begin
            m_waited = m_waited + 1;
            if (m_waited == TIMEOUT) m_phase = 2;
         end
      end else begin
         if (fault_clr) m_phase = 0;
      end
   endtask

   // apply one cycle of inputs, returning at the following falling edge
   task automatic cyc(input logic f, input logic pl, input logic [15:0] plv,
                      input logic fc, input logic rdy, input logic [15:0] rd);
      fetch         = f;
      pc_load       = pl;
      pc_load_value = plv;
      fault_clr     = fc;
      mem_ready     = rdy;
      mem_rdata     = rd;
      model_step();
      @(negedge clock);
   endtask

   // compare every DUT output against the model shortly after each rising edge
   always begin
      @(posedge clock);
      #2;
      if (cmp_en) begin
         chk1 ("mem_rd",      mem_rd,      m_phase == 1);
         chk1 ("busy",        busy,        m_phase == 1);
         chk1 ("fetch_fault", fetch_fault, m_phase == 2);
         chk1 ("ir_valid",    ir_valid,    m_irv);
         chk16("PC",          PC,          m_pc);
         chk16("mem_addr",    mem_addr,    m_pc);
         chk16("IR",          IR,          m_ir);
      end
   end

   initial begin
      reset = 1'b0;
      fetch = 1'b0; pc_load = 1'b0; pc_load_value = 16'h0000;
      fault_clr = 1'b0; mem_rdata = 16'h0000; mem_ready = 1'b0;
      model_reset();
      cmp_en = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk16("rst_pc", PC, 16'h0000);
      chk16("rst_ir", IR, 16'h0000);
      chk1 ("rst_mem_rd", mem_rd, 1'b0);
      chk1 ("rst_fault", fetch_fault, 1'b0);
      reset = 1'b1;

      // basic fetch, accepted on the first edge after reset release
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      chk1 ("basic_mem_rd_on", mem_rd, 1'b1);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hA5C3);
      chk16("basic_ir", IR, 16'hA5C3);
      chk16("basic_pc", PC, 16'h0001);
      chk1 ("basic_valid", ir_valid, 1'b1);
      chk1 ("basic_mem_rd_off", mem_rd, 1'b0);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      chk1 ("basic_valid_once", ir_valid, 1'b0);

      // wrap at 16'hFFFF with a three-cycle ready delay
      cyc(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000);
      chk16("wrap_addr", mem_addr, 16'hFFFF);
      chk1 ("wrap_busy1", busy, 1'b1);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      chk1 ("wrap_busy2", busy, 1'b1);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      chk1 ("wrap_busy3", busy, 1'b1);
      chk16("wrap_addr_wait", mem_addr, 16'hFFFF);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234);
      chk1 ("wrap_busy_off", busy, 1'b0);
      chk16("wrap_pc", PC, 16'h0000);
      chk16("wrap_ir", IR, 16'h1234);

      // mem_ready outside WAIT has no effect
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hDEAD);
      chk16("idle_ready_ir", IR, 16'h1234);
      chk1 ("idle_ready_valid", ir_valid, 1'b0);

      // branch and fetch on the same edge
      cyc(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000);
      chk16("branch_addr", mem_addr, 16'h0040);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
      chk16("branch_pc", PC, 16'h0041);

      // fetch and pc_load during WAIT are ignored
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cyc(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000);
      chk16("wait_ignore_addr", mem_addr, 16'h0041);
      cyc(1'b1, 1'b1, 16'h0100, 1'b0, 1'b1, 16'hC0DE);
      chk16("wait_ignore_pc", PC, 16'h0042);
      chk16("wait_ignore_ir", IR, 16'hC0DE);

      // timeout into FAULT, recovery, then a clean fetch
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      for (int i = 1; i < TIMEOUT; i++) begin
         cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      end
      chk1 ("to_busy_last", busy, 1'b1);
      chk1 ("to_no_fault_yet", fetch_fault, 1'b0);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      chk1 ("to_fault", fetch_fault, 1'b1);
      chk1 ("to_mem_rd", mem_rd, 1'b0);
      chk16("to_pc", PC, 16'h0042);
      chk16("to_ir", IR, 16'hC0DE);
      cyc(1'b1, 1'b1, 16'h0300, 1'b0, 1'b1, 16'h5555);
      chk1 ("fault_hold", fetch_fault, 1'b1);
      chk16("fault_hold_pc", PC, 16'h0042);
      cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      chk1 ("fault_clr", fetch_fault, 1'b0);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h7777);
      chk16("recover_ir", IR, 16'h7777);
      chk16("recover_pc", PC, 16'h0043);

      // reset asserted mid-WAIT aborts the fetch at once
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      chk1 ("pre_rst_mem_rd", mem_rd, 1'b1);
      fetch     = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 16'h9999;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk1 ("midrst_mem_rd", mem_rd, 1'b0);
      chk16("midrst_pc", PC, 16'h0000);
      chk16("midrst_ir", IR, 16'h0000);
      chk1 ("midrst_valid", ir_valid, 1'b0);
      @(negedge clock);
      reset     = 1'b1;
      mem_ready = 1'b0;
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      chk1 ("postrst_valid", ir_valid, 1'b0);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1111);
      chk16("postrst_ir", IR, 16'h1111);
      chk16("postrst_pc", PC, 16'h0001);

      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 15, is the maximum number of WAIT cycles before a fault; legal range 1..255.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (reset=0 resets).
REQ-005 fetch  in  1  control-unit request to fetch the instruction at PC.
REQ-006 pc_load  in  1  branch or jump request; loads PC from pc_load_value.
REQ-007 pc_load_value  in  16  branch target.
REQ-008 fault_clr  in  1  clears the FAULT state.
REQ-009 mem_rdata  in  16  instruction word from memory.
REQ-010 mem_ready  in  1  memory indicates mem_rdata is valid this cycle.
REQ-011 mem_rd  out  1  memory read strobe.
REQ-012 mem_addr  out  16  memory address; always equals PC.
REQ-013 IR  out  16  instruction register; feeds the control unit IR input.
REQ-014 PC  out  16  program counter.
REQ-015 ir_valid  out  1  one-cycle pulse when IR has just been updated.
REQ-016 busy  out  1  high in WAIT state.
REQ-017 fetch_fault  out  1  high in FAULT state.

Function
REQ-018 The FSM SHALL have three states: IDLE, WAIT and FAULT; all outputs are registered or decoded from state, with no combinational input-to-output path.
REQ-019 In IDLE, fetch=1 SHALL go to WAIT on the next edge, clearing the wait counter.
REQ-020 In IDLE, pc_load=1 SHALL set PC to pc_load_value; if fetch=1 on the same edge, the fetch uses the new PC.
REQ-021 mem_rd SHALL be 1 exactly while in WAIT, so fetch sampled at edge k gives mem_rd=1 from cycle k+1.
REQ-022 In WAIT with mem_ready=1, the edge SHALL load IR from mem_rdata, set PC to PC+1 (modulo 2^16, so 16'hFFFF wraps to 16'h0000), set ir_valid=1 for one cycle, and return to IDLE.
REQ-023 In WAIT with mem_ready=0, the wait counter SHALL increment; when the counter reaches TIMEOUT_CYCLES, the FSM goes to FAULT with PC and IR unchanged.
REQ-024 In WAIT, fetch and pc_load SHALL be ignored.
REQ-025 mem_ready SHALL be ignored outside WAIT.
REQ-026 In FAULT, mem_rd=0 and fetch_fault=1; fault_clr=1 returns to IDLE on the next edge, and all other inputs are ignored.
REQ-027 ir_valid SHALL never be high for two consecutive cycles, because WAIT lasts at least one cycle.
REQ-028 The minimum fetch latency SHALL be 2 cycles: fetch at edge k, mem_ready=1 at edge k+1, IR valid after edge k+1.

Reset
REQ-029 When reset=0, the block SHALL asynchronously force state=IDLE, PC=RESET_PC, IR=16'h0000, ir_valid=0, wait counter=0, so mem_rd, busy and fetch_fault are 0.
REQ-030 Reset asserted mid-fetch SHALL abort the fetch with no IR update, and mem_rd SHALL drop immediately.
REQ-031 After reset deasserts, the block SHALL accept a fetch on the first rising edge.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE/WAIT/FAULT), the 16-bit word-width constant, and the default RESET_PC.
REQ-033 The PC register SHALL be a sub-module, pc_register, with load, increment and async active-low reset; load and increment are never asserted together.
REQ-034 The counter width SHALL be 8 bits; IR and the FSM SHALL live in instr_fetch_unit.

Verification
REQ-035 Reset, then fetch=1 for one cycle, with mem_ready=1 one cycle later and mem_rdata=16'hA5C3 -> IR=16'hA5C3, PC=16'h0001, a single ir_valid pulse, mem_rd high for exactly 1 cycle.
REQ-036 PC=16'hFFFF, fetch with a 3-cycle ready delay -> busy high for 3 cycles, PC wraps to 16'h0000, mem_addr=16'hFFFF during WAIT.
REQ-037 pc_load=1 with pc_load_value=16'h0040 together with fetch=1 in IDLE -> mem_addr=16'h0040, then PC=16'h0041 after ready.
REQ-038 Fetch, then mem_ready held 0 -> fetch_fault=1 after 15 WAIT cycles, IR and PC unchanged; fault_clr=1 -> IDLE; a subsequent fetch succeeds.
REQ-039 reset=0 asserted in the middle of WAIT -> mem_rd=0 immediately, PC=RESET_PC, IR=16'h0000, no ir_valid pulse.
REQ-040 pc_load=1 and fetch=1 asserted during WAIT -> both ignored; after ready, PC=old PC+1.
